// File: rtl/psys_axis_pkg.sv
// Shared constants and helpers for the AXI-Stream width upsizer slice.
package psys_axis_pkg;

    // Default geometry: 128-bit DMA beats packed twelve to a word.
    localparam int DEF_IN_W  = 128;
    localparam int DEF_RATIO = 12;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Lowest bit index of lane k in a packed word of in_w-bit lanes.
    function automatic int lane_lo(input int k, input int in_w);
        return k * in_w;
    endfunction

endpackage

// File: rtl/axis_width_upsizer_if.sv
// Narrow input stream plus wide output stream of the upsizer.
// slave: the upsizer itself; master: whatever drives and drains it.
interface axis_width_upsizer_if
    import psys_axis_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int RATIO = DEF_RATIO
);
    localparam int OUT_W = IN_W * RATIO;

    logic [IN_W-1:0]  s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tlast;
    logic             s_axis_tready;

    logic [OUT_W-1:0] m_axis_tdata;
    logic [RATIO-1:0] m_axis_tkeep;
    logic             m_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );

endinterface

// File: rtl/axis_width_upsizer_acc.sv
// Lane accumulator: lane counter, lane-write data, keep flags and word completion.
// word_*_o present the accumulator with the current beat already merged in,
// so a completing beat can be handed to the output stage in the same cycle.
module axis_upsizer_acc
    import psys_axis_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int RATIO = DEF_RATIO,
    parameter int CNT_W = clog2(RATIO)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic [IN_W-1:0]       wr_data_i,
    input  logic                  wr_last_i,
    input  logic                  clear_i,
    output logic [IN_W*RATIO-1:0] word_data_o,
    output logic [RATIO-1:0]      word_keep_o,
    output logic                  word_last_o,
    output logic                  complete_o
);
    localparam int              OUT_W     = IN_W * RATIO;
    localparam logic [CNT_W:0]  LAST_LANE = (CNT_W+1)'(RATIO - 1);

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [RATIO-1:0] keep_q, keep_d;
    logic             last_q, last_d;

    // A beat completes the word on the top lane or when it carries tlast.
    assign complete_o = wr_i & (({1'b0, cnt_q} == LAST_LANE) | wr_last_i);

    // Merge the incoming beat into lane cnt.
    always_comb begin
        // NOTE: each combinational output gets a default first so no path infers a latch.
        word_data_o = data_q;
        word_keep_o = keep_q;
        word_last_o = last_q | (wr_i & wr_last_i);
        for (int k = 0; k < RATIO; k++) begin
            if (wr_i && cnt_q == CNT_W'(k)) begin
                word_data_o[lane_lo(k, IN_W) +: IN_W] = wr_data_i;
                word_keep_o[k]                       = 1'b1;
            end
        end
    end

    // Clear when the word leaves, otherwise absorb the beat and advance the lane.
    always_comb begin
        data_d = data_q;
        keep_d = keep_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            data_d = '0;
            keep_d = '0;
            last_d = 1'b0;
            cnt_d  = '0;
        end else if (wr_i) begin
            data_d = word_data_o;
            keep_d = word_keep_o;
            last_d = word_last_o;
            if (!complete_o) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the wide data array is reset as well, so a flushed partial word never shows stale lanes.
        if (!rst_n) begin
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            data_q <= data_d;
            keep_q <= keep_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_width_upsizer.sv
// AXI-Stream width upsizer: packs RATIO beats of IN_W bits into one word,
// first beat in lane 0, with tlast partial flush and a one-word holding stage.
module axis_width_upsizer
    import psys_axis_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int RATIO = DEF_RATIO
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axis_width_upsizer_if.slave  axis
);
    localparam int CNT_W = clog2(RATIO);
    localparam int OUT_W = IN_W * RATIO;

    generate
        if (RATIO < 2 || RATIO > 64) begin : g_bad_ratio
            $error("axis_width_upsizer: RATIO must be in 2..64");
        end
        if (IN_W < 8 || (IN_W % 8) != 0) begin : g_bad_in_w
            $error("axis_width_upsizer: IN_W must be a multiple of 8 and at least 8");
        end
    endgenerate

    logic             s_ready_q,  s_ready_d;
    logic             acc_full_q, acc_full_d;
    logic             m_valid_q,  m_valid_d;
    logic [OUT_W-1:0] m_data_q,   m_data_d;
    logic [RATIO-1:0] m_keep_q,   m_keep_d;
    logic             m_last_q,   m_last_d;

    logic             accept;
    logic             out_free;
    logic             load;
    logic             complete;
    logic [OUT_W-1:0] word_data;
    logic [RATIO-1:0] word_keep;
    logic             word_last;

    assign accept   = axis.s_axis_tvalid & s_ready_q;
    assign out_free = ~m_valid_q | axis.m_axis_tready;
    // A word moves to the output either straight from a completing beat or
    // from the held accumulator; while held, no beat is accepted.
    assign load     = out_free & (complete | acc_full_q);

    axis_upsizer_acc #(
        .IN_W  (IN_W),
        .RATIO (RATIO),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_i        (accept),
        .wr_data_i   (axis.s_axis_tdata),
        .wr_last_i   (axis.s_axis_tlast),
        .clear_i     (load),
        .word_data_o (word_data),
        .word_keep_o (word_keep),
        .word_last_o (word_last),
        .complete_o  (complete)
    );

    // Output register load/unload and the accumulator-full handshake.
    always_comb begin
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;
        acc_full_d = acc_full_q;
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = word_data;
            m_keep_d  = word_keep;
            m_last_d  = word_last;
        end else if (m_valid_q && axis.m_axis_tready) begin
            m_valid_d = 1'b0;
        end
        if (acc_full_q && out_free) begin
            acc_full_d = 1'b0;
        end else if (complete && !out_free) begin
            acc_full_d = 1'b1;
        end
        s_ready_d = ~acc_full_d;
    end

    // Output stage and ready flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_q  <= 1'b1;
            acc_full_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
        end else begin
            s_ready_q  <= s_ready_d;
            acc_full_q <= acc_full_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
        end
    end

    assign axis.s_axis_tready = s_ready_q;
    assign axis.m_axis_tvalid = m_valid_q;
    assign axis.m_axis_tdata  = m_data_q;
    assign axis.m_axis_tkeep  = m_keep_q;
    assign axis.m_axis_tlast  = m_last_q;

endmodule
